// File: rtl/sqrt_stream_pkg.sv
// Shared types and sizing helpers for the streaming restoring square-root unit.
package sqrt_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int iter_f(input int n, input int q);
    return (n + q) / 2;
  endfunction

  function automatic int cycles_f(input int iter, input int unroll);
    return (iter + unroll - 1) / unroll;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational digit of the restoring square root: trial subtract,
// choose the root bit, then bring down the next two radicand bits.
module sqrt_step #(
  parameter int N = 8
) (
  input  logic [N+1:0] ac_in,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] q_in,
  output logic [N+1:0] ac_next,
  output logic [N-1:0] x_next,
  output logic [N-1:0] q_next
);

  logic [N+1:0]   test;
  logic [N+1:0]   ac_t;
  logic [2*N+1:0] shifted;

  always_comb begin
    test = ac_in - {q_in, 2'b01};
    if (!test[N+1]) begin
      ac_t   = test;
      q_next = {q_in[N-2:0], 1'b1};
    end else begin
      ac_t   = ac_in;
      q_next = {q_in[N-2:0], 1'b0};
    end
    shifted = {ac_t, x_in} << 2;
    ac_next = shifted[2*N+1:N];
    x_next  = shifted[N-1:0];
  end

endmodule

// File: rtl/sqrt_stream.sv
// Streaming fixed-point square root, UNROLL restoring iterations per clock.
// Define SQRT_STREAM_ROUND_EN to add a one-cycle round-to-nearest stage.
module sqrt_stream
  import sqrt_stream_pkg::*;
#(
  parameter int N      = 8,
  parameter int Q      = 0,
  parameter int UNROLL = 1
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         abort_in,
  input  logic         in_valid_in,
  output logic         in_ready_out,
  input  logic [N-1:0] rad_in,
  output logic         out_valid_out,
  input  logic         out_ready_in,
  output logic [N-1:0] root_out,
  output logic [N-1:0] rem_out,
  output logic         exact_out,
  output logic         busy_out
);

  localparam int ITER       = iter_f(N, Q);
  localparam int CYCLES     = cycles_f(ITER, UNROLL);
  localparam int CNT_W      = $clog2(CYCLES + 1);
  localparam int LAST_ITERS = ITER - (CYCLES - 1) * UNROLL;

  if ((N + Q) % 2 != 0) begin : g_bad_nq
    $error("sqrt_stream: N+Q must be even");
  end
  if (UNROLL < 1 || UNROLL > ITER) begin : g_bad_unroll
    $error("sqrt_stream: UNROLL must lie in 1..ITER");
  end

  state_e     state_q, state_d;
  logic [N+1:0] ac_q, ac_d;
  logic [N-1:0] x_q, x_d, q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0] root_q, root_d, rem_q, rem_d;
  logic         exact_q, exact_d;
  logic         in_ready_q, out_valid_q, busy_q;
  logic         last_cycle;

  assign last_cycle = (count_q == CNT_W'(CYCLES - 1));

  // Stages past the end of a short final cycle pass their inputs through.
  for (genvar s = 0; s < UNROLL; s++) begin : g_stage
    logic [N+1:0] ac_i, ac_n, ac_o;
    logic [N-1:0] x_i, x_n, x_o, q_i, q_n, q_o;
    logic         en;
    if (s == 0) begin : g_first
      assign ac_i = ac_q;
      assign x_i  = x_q;
      assign q_i  = q_q;
    end else begin : g_chain
      assign ac_i = g_stage[s-1].ac_o;
      assign x_i  = g_stage[s-1].x_o;
      assign q_i  = g_stage[s-1].q_o;
    end
    sqrt_step #(.N(N)) u_step (
      .ac_in  (ac_i),
      .x_in   (x_i),
      .q_in   (q_i),
      .ac_next(ac_n),
      .x_next (x_n),
      .q_next (q_n)
    );
    assign en   = !last_cycle || (s < LAST_ITERS);
    assign ac_o = en ? ac_n : ac_i;
    assign x_o  = en ? x_n  : x_i;
    assign q_o  = en ? q_n  : q_i;
  end

  logic [N+1:0] ac_fin;
  logic [N-1:0] rem_fin;
  assign ac_fin  = g_stage[UNROLL-1].ac_o;
  assign rem_fin = ac_fin[N+1:2];

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    x_d     = x_q;
    q_d     = q_q;
    count_d = count_q;
    root_d  = root_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    if (abort_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_in) begin
            {ac_d, x_d} = {{N{1'b0}}, rad_in, 2'b00};
            q_d         = '0;
            count_d     = '0;
            state_d     = CALC;
          end
        end
        CALC: begin
          ac_d    = ac_fin;
          x_d     = g_stage[UNROLL-1].x_o;
          q_d     = g_stage[UNROLL-1].q_o;
          count_d = count_q + CNT_W'(1);
          if (last_cycle) begin
            root_d  = g_stage[UNROLL-1].q_o;
            rem_d   = rem_fin;
            exact_d = (rem_fin == '0);
`ifdef SQRT_STREAM_ROUND_EN
            state_d = RND;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef SQRT_STREAM_ROUND_EN
        // rem > root means rad lies past (root+0.5)^2, so round up.
        RND: begin
          if (rem_q > root_q) root_d = root_q + N'(1);
          state_d = DONE;
        end
`endif
        DONE: begin
          if (out_ready_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      ac_q        <= '0;
      x_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      exact_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ac_q        <= ac_d;
      x_q         <= x_d;
      q_q         <= q_d;
      count_q     <= count_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      exact_q     <= exact_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == CALC) || (state_d == RND);
    end
  end

  assign in_ready_out  = in_ready_q;
  assign out_valid_out = out_valid_q;
  assign busy_out      = busy_q;
  assign root_out      = root_q;
  assign rem_out       = rem_q;
  assign exact_out     = exact_q;

endmodule

// File: tb/tb_sqrt_stream.sv
// Directed bench for sqrt_stream: three configurations share clock, reset and abort.
module tb_sqrt_stream;

`ifdef SQRT_STREAM_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif
  localparam int LAT0 = 4 + ROUND;
  localparam int LAT1 = 6 + ROUND;
  localparam int LAT2 = 2 + ROUND;

  logic clk = 1'b0;
  logic rstN;
  logic abort;
  logic [2:0] inValid, outReady;
  logic [2:0] inReady, outValid, busy, exact;
  logic [15:0] radBus;
  logic [7:0]  root0, rem0, root2, rem2;
  logic [15:0] root1, rem1;
  logic [15:0] rootSel [3];
  logic [15:0] remSel [3];

  int compared = 0;
  int mismatched = 0;
  int lastRoot0 = 0;

  always #5 clk = ~clk;

  sqrt_stream #(.N(8), .Q(0), .UNROLL(1)) dut0 (
    .clk_in(clk), .rst_n_in(rstN), .abort_in(abort),
    .in_valid_in(inValid[0]), .in_ready_out(inReady[0]), .rad_in(radBus[7:0]),
    .out_valid_out(outValid[0]), .out_ready_in(outReady[0]),
    .root_out(root0), .rem_out(rem0), .exact_out(exact[0]), .busy_out(busy[0]));

  sqrt_stream #(.N(16), .Q(8), .UNROLL(2)) dut1 (
    .clk_in(clk), .rst_n_in(rstN), .abort_in(abort),
    .in_valid_in(inValid[1]), .in_ready_out(inReady[1]), .rad_in(radBus),
    .out_valid_out(outValid[1]), .out_ready_in(outReady[1]),
    .root_out(root1), .rem_out(rem1), .exact_out(exact[1]), .busy_out(busy[1]));

  sqrt_stream #(.N(8), .Q(0), .UNROLL(3)) dut2 (
    .clk_in(clk), .rst_n_in(rstN), .abort_in(abort),
    .in_valid_in(inValid[2]), .in_ready_out(inReady[2]), .rad_in(radBus[7:0]),
    .out_valid_out(outValid[2]), .out_ready_in(outReady[2]),
    .root_out(root2), .rem_out(rem2), .exact_out(exact[2]), .busy_out(busy[2]));

  assign rootSel[0] = {8'h00, root0};
  assign rootSel[1] = root1;
  assign rootSel[2] = {8'h00, root2};
  assign remSel[0]  = {8'h00, rem0};
  assign remSel[1]  = rem1;
  assign remSel[2]  = {8'h00, rem2};

  typedef struct {
    int rad;
    int root;
    int rootR;
    int rem;
    int ex;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitResult(input int d, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (outValid[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int d, input int rad, output int lat);
    @(negedge clk);
    checkOutput("in_ready before accept", int'(inReady[d]), 1);
    inValid[d] = 1'b1;
    radBus     = rad[15:0];
    @(posedge clk);
    #1;
    inValid[d] = 1'b0;
    waitResult(d, lat);
  endtask

  task automatic releaseOutput(input int d);
    @(negedge clk);
    outReady[d] = 1'b1;
    @(posedge clk);
    #1;
    outReady[d] = 1'b0;
    checkOutput("out_valid after handshake", int'(outValid[d]), 0);
  endtask

  task automatic runJob(input int d, input int rad, input int eRoot, input int eRem,
                        input int eEx, input int eLat, input string tag);
    int lat;
    applyStimulus(d, rad, lat);
    checkOutput({tag, " latency"}, lat, eLat);
    checkOutput({tag, " root"}, int'(rootSel[d]), eRoot);
    checkOutput({tag, " rem"}, int'(remSel[d]), eRem);
    checkOutput({tag, " exact"}, int'(exact[d]), eEx);
    releaseOutput(d);
  endtask

  initial begin
    int lat;
    bit sawValid;

    vecs[0] = '{rad: 200, root: 14, rootR: 14, rem: 4,  ex: 0};
    vecs[1] = '{rad: 255, root: 15, rootR: 16, rem: 30, ex: 0};
    vecs[2] = '{rad: 0,   root: 0,  rootR: 0,  rem: 0,  ex: 1};
    vecs[3] = '{rad: 144, root: 12, rootR: 12, rem: 0,  ex: 1};
    vecs[4] = '{rad: 1,   root: 1,  rootR: 1,  rem: 0,  ex: 1};
    vecs[5] = '{rad: 2,   root: 1,  rootR: 1,  rem: 1,  ex: 0};
    vecs[6] = '{rad: 99,  root: 9,  rootR: 10, rem: 18, ex: 0};
    vecs[7] = '{rad: 210, root: 14, rootR: 14, rem: 14, ex: 0};
    vecs[8] = '{rad: 211, root: 14, rootR: 15, rem: 15, ex: 0};

    rstN = 1'b0; abort = 1'b0; inValid = '0; outReady = '0; radBus = '0;
    #12;
    checkOutput("reset in_ready", int'(inReady[0]), 1);
    checkOutput("reset out_valid", int'(outValid[0]), 0);
    checkOutput("reset busy", int'(busy[0]), 0);
    checkOutput("reset root", int'(root0), 0);
    checkOutput("reset rem", int'(rem0), 0);
    checkOutput("reset exact", int'(exact[0]), 0);
    #10 rstN = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runJob(0, vecs[i].rad, (ROUND != 0) ? vecs[i].rootR : vecs[i].root,
             vecs[i].rem, vecs[i].ex, LAT0, $sformatf("n8u1 vec%0d", i));
    end

    runJob(1, 16'h0200, 16'h016A, 28, 0, LAT1, "n16q8 two");
    runJob(1, 16'h0400, 16'h0200, 0, 1, LAT1, "n16q8 four");
    runJob(1, 16'hFFFF, (ROUND != 0) ? 16'h1000 : 16'h0FFF, 7935, 0, LAT1, "n16q8 ones");
    runJob(2, 144, 12, 0, 1, LAT2, "n8u3 144");
    runJob(2, 255, (ROUND != 0) ? 16 : 15, 30, 0, LAT2, "n8u3 255");

    // Backpressure: result held while a new radicand waits.
    applyStimulus(0, 200, lat);
    checkOutput("bp latency", lat, LAT0);
    @(negedge clk);
    inValid[0] = 1'b1;
    radBus     = 16'd99;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp root hold", int'(root0), 14);
      checkOutput("bp rem hold", int'(rem0), 4);
      checkOutput("bp out_valid hold", int'(outValid[0]), 1);
      checkOutput("bp in_ready low", int'(inReady[0]), 0);
    end
    @(negedge clk);
    outReady[0] = 1'b1;
    @(posedge clk);
    #1;
    outReady[0] = 1'b0;
    checkOutput("bp handshake out_valid", int'(outValid[0]), 0);
    checkOutput("bp handshake in_ready", int'(inReady[0]), 1);
    checkOutput("bp not accepted on handshake", int'(busy[0]), 0);
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    checkOutput("bp accepted next clock", int'(busy[0]), 1);
    waitResult(0, lat);
    checkOutput("bp second latency", lat, LAT0);
    checkOutput("bp second root", int'(root0), (ROUND != 0) ? 10 : 9);
    checkOutput("bp second rem", int'(rem0), 18);
    releaseOutput(0);
    lastRoot0 = (ROUND != 0) ? 10 : 9;

    // Abort in the second CALC cycle.
    @(negedge clk);
    inValid[0] = 1'b1;
    radBus     = 16'd255;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    #1;
    abort      = 1'b1;
    inValid[0] = 1'b1;
    radBus     = 16'd200;
    @(posedge clk);
    #1;
    abort      = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("abort busy", int'(busy[0]), 0);
    checkOutput("abort out_valid", int'(outValid[0]), 0);
    checkOutput("abort in_ready", int'(inReady[0]), 1);
    checkOutput("abort root kept", int'(root0), lastRoot0);
    sawValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (outValid[0]) sawValid = 1'b1;
    end
    checkOutput("abort no result", int'(sawValid), 0);

    // Input offered together with abort while idle must be dropped.
    @(negedge clk);
    abort      = 1'b1;
    inValid[0] = 1'b1;
    radBus     = 16'd200;
    @(posedge clk);
    #1;
    abort      = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("abort idle not accepted", int'(busy[0]), 0);
    checkOutput("abort idle in_ready", int'(inReady[0]), 1);
    runJob(0, 200, 14, 4, 0, LAT0, "after abort");

    // Asynchronous reset in the middle of a dut1 job.
    @(negedge clk);
    inValid[1] = 1'b1;
    radBus     = 16'h0200;
    @(posedge clk);
    #1;
    inValid[1] = 1'b0;
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("rst busy", int'(busy[1]), 0);
    checkOutput("rst in_ready", int'(inReady[1]), 1);
    checkOutput("rst out_valid", int'(outValid[1]), 0);
    checkOutput("rst root", int'(root1), 0);
    checkOutput("rst rem", int'(rem1), 0);
    checkOutput("rst exact", int'(exact[1]), 0);
    @(negedge clk);
    rstN = 1'b1;
    runJob(1, 16'h0200, 16'h016A, 28, 0, LAT1, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
